// File: rtl/router_pkg.sv
// Shared definitions for the router port receive path and switching core.
package router_pkg;

    localparam int NUM_PORTS = 16;
    localparam int BYTE_W    = 8;
    localparam int PORT_W    = $clog2(NUM_PORTS);

    // Serial parser states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_PAD  = 2'd2,
        S_DATA = 2'd3
    } rx_state_e;

    // One tagged byte as handed to the switching core
    typedef struct packed {
        logic [PORT_W-1:0] addr;
        logic [BYTE_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              err;
    } rx_entry_t;

endpackage

// File: rtl/router_port_rx_if.sv
// Byte-stream handshake between a port receiver (master) and the switching core (slave).
interface router_port_rx_if
    import router_pkg::*;
#(
    parameter int ADDR_BITS = 4
);
    logic                 out_valid;
    logic                 out_ready;
    logic [BYTE_W-1:0]    out_data;
    logic [ADDR_BITS-1:0] out_addr;
    logic                 out_sop;
    logic                 out_eop;
    logic                 out_err;

    modport master (
        output out_valid, out_data, out_addr, out_sop, out_eop, out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_addr, out_sop, out_eop, out_err,
        output out_ready
    );
endinterface

// File: rtl/router_rx_fifo.sv
// First-word-fall-through synchronous FIFO. Pointers carry one extra wrap bit
// so full/empty come from comparing the MSBs. A pop frees a slot for a push
// in the same cycle, so a full FIFO still accepts a write while draining.
module router_rx_fifo
    import router_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = rx_entry_t
) (
    input  logic clock,
    input  logic reset,
    input  logic wr_en,
    input  T     wr_data,
    input  logic rd_en,
    output T     rd_data,
    output logic valid,
    output logic full
);
    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         empty;
    logic         pop;
    logic         push;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = rd_en && !empty;
    assign push    = wr_en && (!full || pop);
    assign valid   = !empty;
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    // Storage array, written only on an accepted push
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/router_port_rx.sv
// Per-port serial receiver: parses din/frame_n/valid_n into tagged bytes and
// buffers them for the switching core. The last byte of a packet is held in a
// staging register so it can be tagged eop once the frame end is seen; the
// eop push happens in the cycle after frame end (fin_q). A packet that loses
// data to a full FIFO ends with an error marker parked in a tail register.
// Optional statistics counters: define ROUTER_PORT_RX_STATS_EN.
module router_port_rx
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_BITS  = 4,
    parameter int PAD_CYCLES = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             din,
    input  logic             frame_n,
    input  logic             valid_n,
    router_port_rx_if.master out_if,
    output logic             busy,
    output logic [15:0]      pkt_count,
    output logic [15:0]      err_count
);
    localparam int CNT_MAX = (ADDR_BITS > PAD_CYCLES) ? ADDR_BITS : PAD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BCW     = $clog2(BYTE_W);

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [BYTE_W-1:0]    data;
        logic                 sop;
        logic                 eop;
        logic                 err;
    } entry_t;

    rx_state_e            state_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic [BCW-1:0]       bit_cnt_d;
    logic [BYTE_W-1:0]    byte_q;
    logic [BYTE_W-1:0]    staged_data_q;
    logic                 staged_valid_q;
    logic                 pushed_any_q;
    logic                 proto_err_q;
    logic                 ovf_q;
    logic                 trunc_q;
    logic                 fin_q;
    logic                 sync_wait_q;
    logic                 tail_pend_q;
    entry_t               tail_q;

    logic [BYTE_W-1:0]    new_byte;
    logic                 byte_done;
    logic                 pop;
    logic                 can_wr;
    logic                 tail_go;
    logic                 fin_go;
    logic                 stage_go;
    logic                 wr_en;
    entry_t               wr_entry;
    entry_t               stage_entry;
    entry_t               marker;
    entry_t               fin_entry;
    entry_t               head;
    entry_t               head_vis;
    logic                 fifo_valid;
    logic                 fifo_full;

    assign bit_cnt_d   = bit_cnt_q + {{(BCW-1){1'b0}}, !valid_n};
    assign new_byte    = {din, byte_q[BYTE_W-2:0]};
    assign byte_done   = (state_q == S_DATA) && !valid_n && (bit_cnt_q == {BCW{1'b1}});
    assign pop         = out_if.out_ready && fifo_valid;
    assign can_wr      = !fifo_full || pop;
    // The tail marker of an earlier packet always wins the write port
    assign tail_go     = tail_pend_q && can_wr;
    assign fin_go      = fin_q && !tail_pend_q && can_wr;
    assign stage_go    = byte_done && staged_valid_q && !ovf_q && !tail_pend_q && can_wr;
    assign wr_en       = tail_go || fin_go || stage_go;

    assign stage_entry = '{addr: addr_q, data: staged_data_q, sop: !pushed_any_q, eop: 1'b0, err: 1'b0};
    assign marker      = '{addr: addr_q, data: '0, sop: !pushed_any_q, eop: 1'b1, err: 1'b1};

    // Closing entry: the staged byte if the packet kept its data, else a marker
    always_comb begin
        fin_entry = marker;
        if (!ovf_q && staged_valid_q) begin
            fin_entry.data = staged_data_q;
            fin_entry.err  = proto_err_q || trunc_q;
        end
    end

    // Write-port mux
    always_comb begin
        wr_entry = stage_entry;
        if (tail_go)     wr_entry = tail_q;
        else if (fin_go) wr_entry = fin_entry;
    end

    // Serial parser FSM with staging register and per-packet error flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            byte_q         <= '0;
            staged_data_q  <= '0;
            staged_valid_q <= 1'b0;
            pushed_any_q   <= 1'b0;
            proto_err_q    <= 1'b0;
            ovf_q          <= 1'b0;
            trunc_q        <= 1'b0;
            fin_q          <= 1'b0;
            sync_wait_q    <= 1'b1;
        end else begin
            fin_q <= 1'b0;
            if (fin_q) staged_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_n) begin
                        sync_wait_q <= 1'b0;
                    end else if (!sync_wait_q) begin
                        addr_q       <= ADDR_BITS'(din);
                        bit_cnt_q    <= '0;
                        pushed_any_q <= 1'b0;
                        proto_err_q  <= 1'b0;
                        ovf_q        <= 1'b0;
                        trunc_q      <= 1'b0;
                        if (ADDR_BITS == 1) begin
                            cnt_q   <= '0;
                            state_q <= S_PAD;
                        end else begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    addr_q <= addr_q | (ADDR_BITS'(din) << cnt_q);
                    cnt_q  <= cnt_q + 1'b1;
                    if (frame_n) begin
                        state_q <= S_IDLE;
                        fin_q   <= 1'b1;
                    end else if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_PAD;
                    end
                end
                S_PAD: begin
                    if (!valid_n) proto_err_q <= 1'b1;
                    cnt_q <= cnt_q + 1'b1;
                    if (frame_n) begin
                        state_q <= S_IDLE;
                        fin_q   <= 1'b1;
                    end else if (cnt_q == CNT_W'(PAD_CYCLES - 1)) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!valid_n) begin
                        byte_q[bit_cnt_q] <= din;
                        bit_cnt_q         <= bit_cnt_d;
                    end
                    if (byte_done && !ovf_q) begin
                        if (!staged_valid_q) begin
                            staged_valid_q <= 1'b1;
                            staged_data_q  <= new_byte;
                        end else if (stage_go) begin
                            staged_data_q  <= new_byte;
                            pushed_any_q   <= 1'b1;
                        end else begin
                            // Blocked push: drop it and everything after
                            ovf_q          <= 1'b1;
                            staged_valid_q <= 1'b0;
                        end
                    end
                    if (frame_n) begin
                        state_q <= S_IDLE;
                        fin_q   <= 1'b1;
                        trunc_q <= (bit_cnt_d != '0);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tail register: holds a closing marker that found the FIFO full. If a
    // second one arrives while the first is still stuck, the second is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tail_pend_q <= 1'b0;
            tail_q      <= '0;
        end else if (fin_q && !fin_go && (!tail_pend_q || tail_go)) begin
            tail_pend_q <= 1'b1;
            tail_q      <= marker;
        end else if (tail_go) begin
            tail_pend_q <= 1'b0;
        end
    end

    router_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (out_if.out_ready),
        .rd_data (head),
        .valid   (fifo_valid),
        .full    (fifo_full)
    );

    // Head fields read as zero while the FIFO is empty
    assign head_vis          = fifo_valid ? head : '0;
    assign out_if.out_valid  = fifo_valid;
    assign out_if.out_data   = head_vis.data;
    assign out_if.out_addr   = head_vis.addr;
    assign out_if.out_sop    = head_vis.sop;
    assign out_if.out_eop    = head_vis.eop;
    assign out_if.out_err    = head_vis.err;
    assign busy              = (state_q != S_IDLE) || fin_q || tail_pend_q;

`ifdef ROUTER_PORT_RX_STATS_EN
    logic [15:0] pkt_count_q;
    logic [15:0] err_count_q;

    // Saturating packet / error counters, stepped on every eop write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else if (wr_en && wr_entry.eop) begin
            if (pkt_count_q != 16'hFFFF) pkt_count_q <= pkt_count_q + 1'b1;
            if (wr_entry.err && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 1'b1;
        end
    end

    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;
`else
    assign pkt_count = '0;
    assign err_count = '0;
`endif
endmodule
